control_tx_network_bridge: RTL and testbench

CONTROL_TX_NETWORK_BRIDGE -- requirements
Module: control_tx_network_bridge

---
 rtl/control_tx_network_bridge.sv | 139 +++++++++++++
 tb/tb_control_tx_network_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_tx_network_bridge.sv
// Bridges single-beat control messages onto the network stream, either as a KIP
// beat or as a LAN header + payload pair. Optional message counters: CTRL_TX_MSG_COUNTER_EN.
module control_tx_network_bridge #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
    parameter int TID_WIDTH        = 8,
    parameter int IP_ADDRESS_WIDTH = 32,
    parameter int IP_PORT_WIDTH    = 16
) (
    input  logic                                     i_clk,
    input  logic                                     i_ap_rst_n,
    input  logic [IP_PORT_WIDTH-1:0]                 i_CTRL_KIP_port_number,
    input  logic                                     from_ctrl_tvalid,
    output logic                                     from_ctrl_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]               from_ctrl_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]               from_ctrl_tkeep,
    input  logic [TID_WIDTH-1:0]                     from_ctrl_tid,
    input  logic [TID_WIDTH-1:0]                     from_ctrl_tdest,
    input  logic [IP_PORT_WIDTH+IP_ADDRESS_WIDTH-1:0] from_ctrl_tuser,
    input  logic                                     from_ctrl_tlast,
    output logic                                     to_network_tvalid,
    input  logic                                     to_network_tready,
    output logic [AXIS_DATA_WIDTH-1:0]               to_network_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]               to_network_tkeep,
    output logic [IP_PORT_WIDTH-1:0]                 to_network_tdest,
    output logic [IP_ADDRESS_WIDTH-1:0]              to_network_tuser,
    output logic                                     to_network_tlast,
    output logic [31:0]                              o_kip_msg_count,
    output logic [31:0]                              o_lan_msg_count
);

    typedef enum logic [1:0] {IDLE, SEND_KIP, SEND_LAN_HDR, SEND_LAN_PAYLOAD} state_t;

    state_t                        state;
    logic [AXIS_DATA_WIDTH-1:0]    cap_data;
    logic [AXIS_KEEP_WIDTH-1:0]    cap_keep;
    logic [TID_WIDTH-1:0]          cap_tid;
    logic [TID_WIDTH-1:0]          cap_tdest;
    logic [IP_PORT_WIDTH-1:0]      cap_port;
    logic [IP_ADDRESS_WIDTH-1:0]   cap_ip;
    logic [AXIS_DATA_WIDTH-1:0]    hdr_data;
    logic [AXIS_KEEP_WIDTH-1:0]    hdr_keep;
    logic                          unused_tlast;

    // Every control message is exactly one beat, so tlast carries no information.
    assign unused_tlast = from_ctrl_tlast;

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state     <= IDLE;
            cap_data  <= '0;
            cap_keep  <= '0;
            cap_tid   <= '0;
            cap_tdest <= '0;
            cap_port  <= '0;
            cap_ip    <= '0;
        end else begin
            case (state)
                IDLE: if (from_ctrl_tvalid) begin
                    cap_data  <= from_ctrl_tdata;
                    cap_keep  <= from_ctrl_tkeep;
                    cap_tid   <= from_ctrl_tid;
                    cap_tdest <= from_ctrl_tdest;
                    cap_ip    <= from_ctrl_tuser[IP_ADDRESS_WIDTH-1:0];
                    cap_port  <= from_ctrl_tuser[IP_ADDRESS_WIDTH +: IP_PORT_WIDTH];
                    // Empty messages are consumed silently.
                    if (from_ctrl_tkeep == '0)
                        state <= IDLE;
                    else if (from_ctrl_tuser[IP_ADDRESS_WIDTH +: IP_PORT_WIDTH] == i_CTRL_KIP_port_number)
                        state <= SEND_KIP;
                    else
                        state <= SEND_LAN_HDR;
                end
                SEND_KIP:         if (to_network_tready) state <= IDLE;
                SEND_LAN_HDR:     if (to_network_tready) state <= SEND_LAN_PAYLOAD;
                SEND_LAN_PAYLOAD: if (to_network_tready) state <= IDLE;
                default:          state <= IDLE;
            endcase
        end
    end

    always_comb begin
        hdr_data = '0;
        hdr_data[TID_WIDTH-1:0]           = cap_tid;
        hdr_data[2*TID_WIDTH-1:TID_WIDTH] = cap_tdest;
        hdr_keep = '0;
        hdr_keep[1:0] = 2'b11;
    end

    // Outputs are a pure decode of state and captured registers.
    always_comb begin
        from_ctrl_tready  = (state == IDLE);
        to_network_tvalid = 1'b0;
        to_network_tdata  = '0;
        to_network_tkeep  = '0;
        to_network_tdest  = '0;
        to_network_tuser  = '0;
        to_network_tlast  = 1'b0;
        case (state)
            SEND_KIP, SEND_LAN_PAYLOAD: begin
                to_network_tvalid = 1'b1;
                to_network_tdata  = cap_data;
                to_network_tkeep  = cap_keep;
                to_network_tdest  = cap_port;
                to_network_tuser  = cap_ip;
                to_network_tlast  = 1'b1;
            end
            SEND_LAN_HDR: begin
                to_network_tvalid = 1'b1;
                to_network_tdata  = hdr_data;
                to_network_tkeep  = hdr_keep;
                to_network_tdest  = cap_port;
                to_network_tuser  = cap_ip;
            end
            default: ;
        endcase
    end

`ifdef CTRL_TX_MSG_COUNTER_EN
    logic [31:0] kip_cnt, lan_cnt;

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            kip_cnt <= '0;
            lan_cnt <= '0;
        end else begin
            if (state == SEND_KIP && to_network_tready)         kip_cnt <= kip_cnt + 32'd1;
            if (state == SEND_LAN_PAYLOAD && to_network_tready) lan_cnt <= lan_cnt + 32'd1;
        end
    end

    assign o_kip_msg_count = kip_cnt;
    assign o_lan_msg_count = lan_cnt;
`else
    assign o_kip_msg_count = '0;
    assign o_lan_msg_count = '0;
`endif

endmodule

// File: tb/tb_control_tx_network_bridge.sv
// Table-driven bench for control_tx_network_bridge with a beat scoreboard.
module tb_control_tx_network_bridge;
    localparam int DW = 512;
    localparam int KW = 64;
    localparam logic [15:0] KIP = 16'h1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   kip_port = KIP;
    logic          c_tvalid = 1'b0;
    logic          c_tready;
    logic [DW-1:0] c_tdata = '0;
    logic [KW-1:0] c_tkeep = '0;
    logic [7:0]    c_tid = '0, c_tdest = '0;
    logic [47:0]   c_tuser = '0;
    logic          c_tlast = 1'b1;
    logic          n_tvalid;
    logic          n_tready = 1'b1;
    logic [DW-1:0] n_tdata;
    logic [KW-1:0] n_tkeep;
    logic [15:0]   n_tdest;
    logic [31:0]   n_tuser;
    logic          n_tlast;
    logic [31:0]   kip_cnt, lan_cnt;

    control_tx_network_bridge dut (
        .i_clk(clk), .i_ap_rst_n(rst_n), .i_CTRL_KIP_port_number(kip_port),
        .from_ctrl_tvalid(c_tvalid), .from_ctrl_tready(c_tready),
        .from_ctrl_tdata(c_tdata), .from_ctrl_tkeep(c_tkeep),
        .from_ctrl_tid(c_tid), .from_ctrl_tdest(c_tdest),
        .from_ctrl_tuser(c_tuser), .from_ctrl_tlast(c_tlast),
        .to_network_tvalid(n_tvalid), .to_network_tready(n_tready),
        .to_network_tdata(n_tdata), .to_network_tkeep(n_tkeep),
        .to_network_tdest(n_tdest), .to_network_tuser(n_tuser),
        .to_network_tlast(n_tlast),
        .o_kip_msg_count(kip_cnt), .o_lan_msg_count(lan_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   port;
        logic [31:0]   ip;
        logic [7:0]    tid;
        logic [7:0]    tdst;
        logic [KW-1:0] keep;
        int            beats;   // expected network beats: 0 drop, 1 KIP, 2 LAN
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [15:0]   dest;
        logic [31:0]   user;
        logic          last;
        int            kind;    // 0 header, 1 KIP final, 2 LAN final
    } beat_t;

    beat_t q[$];
    int n_vec = 0, n_fail = 0;
    int exp_kip = 0, exp_lan = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every beat that handshakes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && n_tvalid && n_tready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                beat_t b;
                b = q.pop_front();
                chk("tdata", n_tdata, b.data);
                chk("tkeep", DW'(n_tkeep), DW'(b.keep));
                chk("tdest", DW'(n_tdest), DW'(b.dest));
                chk("tuser", DW'(n_tuser), DW'(b.user));
                chk("tlast", DW'(n_tlast), DW'(b.last));
                if (b.kind == 1) exp_kip++;
                if (b.kind == 2) exp_lan++;
            end
        end else if (rst_n && !n_tvalid) begin
            chk("idle_zero", DW'(|{n_tdata, n_tkeep, n_tdest, n_tuser, n_tlast}), 0);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input vec_t v, input logic [DW-1:0] data);
        beat_t b;
        int g = 0;
        while (!c_tready && g < 50) begin cyc(); g++; end
        if (!c_tready) chk("ctrl_tready_timeout", 0, 1);
        c_tvalid = 1'b1;
        c_tdata  = data;
        c_tkeep  = v.keep;
        c_tid    = v.tid;
        c_tdest  = v.tdst;
        c_tuser  = {v.port, v.ip};
        if (v.beats == 2) begin
            b.data = '0; b.data[15:0] = {v.tdst, v.tid};
            b.keep = 64'h3; b.dest = v.port; b.user = v.ip; b.last = 1'b0; b.kind = 0;
            q.push_back(b);
        end
        if (v.beats != 0) begin
            b.data = data; b.keep = v.keep; b.dest = v.port; b.user = v.ip; b.last = 1'b1;
            b.kind = (v.beats == 1) ? 1 : 2;
            q.push_back(b);
        end
        cyc();
        c_tvalid = 1'b0;
        if (n_tready) chk("first_beat_latency", DW'(n_tvalid), DW'(v.beats != 0));
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 50) begin cyc(); g++; end
        if (q.size() != 0) chk("drain_timeout", DW'(q.size()), 0);
        cyc();
    endtask

    task automatic chk_counts();
`ifdef CTRL_TX_MSG_COUNTER_EN
        chk("kip_count", DW'(kip_cnt), DW'(exp_kip));
        chk("lan_count", DW'(lan_cnt), DW'(exp_lan));
`else
        chk("kip_count", DW'(kip_cnt), 0);
        chk("lan_count", DW'(lan_cnt), 0);
`endif
    endtask

    function automatic vec_t mk(input logic [15:0] port, input logic [31:0] ip, input logic [7:0] tid,
                                input logic [7:0] tdst, input logic [KW-1:0] keep, input int beats);
        vec_t v;
        v.port = port; v.ip = ip; v.tid = tid; v.tdst = tdst; v.keep = keep; v.beats = beats;
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    vec_t tbl[8];

    initial begin
        tbl[0] = mk(16'h1000, 32'h0A000001, 8'h01, 8'h02, {KW{1'b1}}, 1);
        tbl[1] = mk(16'h2000, 32'h0A000002, 8'h03, 8'h07, {KW{1'b1}}, 2);
        tbl[2] = mk(16'h1000, 32'h0A000003, 8'h04, 8'h05, '0,         0);
        tbl[3] = mk(16'h1000, 32'hC0A80101, 8'h10, 8'h20, 64'hF,      1);
        tbl[4] = mk(16'h1001, 32'h01020304, 8'hFF, 8'h80, 64'hFF00,   2);
        tbl[5] = mk(16'h0000, 32'hFFFFFFFF, 8'h00, 8'h00, 64'h1,      2);
        tbl[6] = mk(16'h2000, 32'h0A000009, 8'h55, 8'hAA, '0,         0);
        tbl[7] = mk(16'h1000, 32'h0A00000A, 8'h11, 8'h22, {KW{1'b1}}, 1);

        repeat (3) cyc();
        chk("reset_ctrl_tready", DW'(c_tready), 1);
        chk("reset_tvalid", DW'(n_tvalid), 0);
        rst_n = 1'b1;
        cyc();
        chk("post_reset_tready", DW'(c_tready), 1);
        chk_counts();

        // Back-to-back at full rate.
        foreach (tbl[i]) send(tbl[i], rnd_data());
        drain();
        chk_counts();

        // Drop: accepted, no network traffic.
        send(tbl[2], rnd_data());
        repeat (3) begin
            chk("drop_no_valid", DW'(n_tvalid), 0);
            cyc();
        end
        chk_counts();

        // Stall in SEND_LAN_HDR for 5 cycles.
        begin
            logic [DW-1:0] sd;
            logic [112:0]  sc;
            n_tready = 1'b0;
            send(tbl[1], rnd_data());
            sd = n_tdata;
            sc = {n_tkeep, n_tdest, n_tuser, n_tlast};
            for (int i = 0; i < 5; i++) begin
                cyc();
                chk("stall_tvalid", DW'(n_tvalid), 1);
                chk("stall_ctrl_tready", DW'(c_tready), 0);
                chk("stall_tdata", n_tdata, sd);
                chk("stall_ctrl", DW'({n_tkeep, n_tdest, n_tuser, n_tlast}), DW'(sc));
            end
            n_tready = 1'b1;
            drain();
            chk_counts();
        end

        // Reset while SEND_LAN_PAYLOAD is stalled.
        n_tready = 1'b0;
        send(tbl[4], rnd_data());
        n_tready = 1'b1;
        cyc();
        n_tready = 1'b0;
        chk("in_payload_tlast", DW'(n_tlast), 1);
        rst_n = 1'b0;
        q.delete();
        exp_kip = 0;
        exp_lan = 0;
        cyc();
        chk("reset_mid_tvalid", DW'(n_tvalid), 0);
        chk_counts();
        rst_n = 1'b1;
        n_tready = 1'b1;
        cyc();
        chk("no_resume", DW'(n_tvalid), 0);
        send(tbl[7], rnd_data());
        drain();
        send(tbl[5], rnd_data());
        drain();
        chk_counts();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
